// File: rtl/plru_set_replacer.sv
// Multi-set tree pseudo-LRU victim selector with invalid-way preference and sequential flush.
// Optional PLRU_LOCK_EN adds lock_mask_i to exclude ways from victimisation.
module plru_set_replacer #(
    parameter int SETS  = 16,
    parameter int WAYS  = 8,
    parameter int SET_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             access_valid_i,
    input  logic [SET_W-1:0] access_set_i,
    input  logic [WAY_W-1:0] access_way_i,
    input  logic             repl_req_valid_i,
    output logic             repl_req_ready_o,
    input  logic [SET_W-1:0] repl_set_i,
    input  logic [WAYS-1:0]  valid_ways_i,
    output logic             repl_rsp_valid_o,
    input  logic             repl_rsp_ready_i,
    output logic [WAY_W-1:0] repl_rsp_way_o,
    input  logic             flush_i,
    output logic             busy_o
`ifdef PLRU_LOCK_EN
    ,
    input  logic [WAYS-1:0]  lock_mask_i
`endif
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [SET_W-1:0] sweep_q;
    logic [WAYS-2:0]  tree_q [SETS];
    logic [WAYS-2:0]  tree_d [SETS];
    logic [WAYS-1:0]  lock_eff;
    logic [WAY_W-1:0] victim;
    logic             req_fire;

`ifdef PLRU_LOCK_EN
    // An all-locked mask would leave no candidate, so it degrades to "nothing locked".
    assign lock_eff = (&lock_mask_i) ? '0 : lock_mask_i;
`else
    assign lock_eff = '0;
`endif

    // Point every node on way w's path away from w.
    function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] w);
        logic [WAYS-2:0] r;
        int              node;
        r = t;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            node    = (1 << lvl) - 1 + int'(w >> (WAY_W - lvl));
            r[node] = ~w[WAY_W-1-lvl];
        end
        return r;
    endfunction

    function automatic logic subtree_locked(input logic [WAYS-1:0] mask, input int lvl, input int prefix);
        logic r;
        r = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (((w >> (WAY_W - lvl)) == prefix) && !mask[w]) r = 1'b0;
        end
        return r;
    endfunction

    // Victim: lowest unlocked invalid way, else the tree walk over the registered tree.
    always_comb begin
        logic [WAYS-2:0]  cur;
        logic [WAY_W-1:0] inv_way;
        logic             inv_found;
        logic             dir;
        int               node;
        int               prefix;
        cur       = tree_q[repl_set_i];
        inv_way   = '0;
        inv_found = 1'b0;
        dir       = 1'b0;
        node      = 0;
        prefix    = 0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_ways_i[w] && !lock_eff[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir = cur[node];
            if (subtree_locked(lock_eff, lvl + 1, prefix * 2 + int'(dir))) dir = ~dir;
            prefix = prefix * 2 + int'(dir);
            node   = 2 * node + 1 + int'(dir);
        end
        victim = inv_found ? inv_way : WAY_W'(prefix);
    end

    // Valid/ready: a request transfers on repl_req_valid_i && repl_req_ready_o; the response
    // is registered, appears the next cycle and holds until repl_rsp_ready_i is seen high.
    assign repl_req_ready_o = !busy_o && (!repl_rsp_valid_o || repl_rsp_ready_i);
    assign req_fire         = repl_req_valid_i && repl_req_ready_o;

    // Hit touch first, allocation touch second so it wins on shared nodes; sweep clears last.
    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            tree_d[s] = tree_q[s];
            if (access_valid_i && !busy_o && int'(access_set_i) == s)
                tree_d[s] = touch(tree_d[s], access_way_i);
            if (req_fire && int'(repl_set_i) == s)
                tree_d[s] = touch(tree_d[s], victim);
            if (state_q == FLUSH && int'(sweep_q) == s)
                tree_d[s] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_i) state_d = FLUSH;
            FLUSH:   if (sweep_q == SET_W'(SETS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == FLUSH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sweep_q          <= '0;
            repl_rsp_valid_o <= 1'b0;
            repl_rsp_way_o   <= '0;
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else begin
            sweep_q <= (state_q == FLUSH) ? sweep_q + 1'b1 : '0;
            if (req_fire) begin
                repl_rsp_valid_o <= 1'b1;
                repl_rsp_way_o   <= victim;
            end else if (repl_rsp_ready_i) begin
                repl_rsp_valid_o <= 1'b0;
            end
            for (int s = 0; s < SETS; s++) tree_q[s] <= tree_d[s];
        end
    end

endmodule
